// File: rtl/sample_fetch_pkg.sv
// Shared types and helpers for the sample frame fetcher: FSM state encoding,
// frame counter width and the circular-region address increment.
package sample_fetch_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int ADDR_MAX_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    PUBLISH = 2'd3
  } fetch_state_t;

  // Addresses are passed zero-extended so one function serves any ADDR_W up to 32.
  function automatic logic [ADDR_MAX_W-1:0] next_addr(
    input logic [ADDR_MAX_W-1:0] ptr,
    input logic [ADDR_MAX_W-1:0] base,
    input logic [ADDR_MAX_W-1:0] limit
  );
    logic [ADDR_MAX_W-1:0] nxt;
    if (ptr == limit) nxt = base;
    else              nxt = ptr + 32'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/sample_frame_fetch_rd_latency_pipe.sv
// Shift register tracking in-flight RAM reads as {valid, index}; the tail stage
// lines up with the cycle the RAM presents the matching data.
module rd_latency_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             inner_busy
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = in_valid;
    idx_d[0] = in_idx;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // Reads still short of the tail; the tail itself is captured this cycle.
  always_comb begin
    inner_busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      inner_busy = inner_busy | vld_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/sample_frame_fetch.sv
// Fetches NUM_SAMPLES-word frames from a fixed-latency RAM and publishes them
// atomically. Build option SAMPLE_ABS_EN stores the magnitude of each sample.
module sample_frame_fetch
  import sample_fetch_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int NUM_SAMPLES = 16,
  parameter int RD_LATENCY  = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W-1:0]             limit_addr,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_rden,
  input  logic [DATA_W-1:0]             ram_q,
  output logic [NUM_SAMPLES*DATA_W-1:0] samples,
  output logic                          frame_valid,
  output logic                          busy,
  output logic [FRAME_CNT_W-1:0]        frame_count,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = $clog2(NUM_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  fetch_state_t                  state_q, state_d;
  logic [ADDR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]              issue_q, issue_d;
  logic [NUM_SAMPLES*DATA_W-1:0] work_q, work_d;
  logic [NUM_SAMPLES*DATA_W-1:0] samples_q, samples_d;
  logic [FRAME_CNT_W-1:0]        fc_q, fc_d;

  logic             cap_valid;
  logic [IDX_W-1:0] cap_idx;
  logic             pipe_busy;
  logic [DATA_W-1:0] cap_data;

  function automatic logic [DATA_W-1:0] sample_conv(input logic [DATA_W-1:0] raw);
`ifdef SAMPLE_ABS_EN
    logic [DATA_W-1:0] neg;
    logic [DATA_W-1:0] res;
    neg = ~raw + 1'b1;
    if (!raw[DATA_W-1])     res = raw;
    // Negating the most negative value overflows back to itself.
    else if (neg[DATA_W-1]) res = {1'b0, {(DATA_W-1){1'b1}}};
    else                    res = neg;
    return res;
`else
    return raw;
`endif
  endfunction

  rd_latency_pipe #(
    .DEPTH (RD_LATENCY),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk        (Clk),
    .rst        (Reset),
    .in_valid   (ram_rden),
    .in_idx     (issue_q),
    .out_valid  (cap_valid),
    .out_idx    (cap_idx),
    .inner_busy (pipe_busy)
  );

  assign cap_data = sample_conv(ram_q);

  always_comb begin
    work_d = work_q;
    if (cap_valid) work_d[cap_idx*DATA_W +: DATA_W] = cap_data;
  end

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    issue_d   = issue_q;
    samples_d = samples_q;
    fc_d      = fc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d = base_addr;
          issue_d  = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        rd_ptr_d = ADDR_W'(next_addr(32'(rd_ptr_q), 32'(base_addr), 32'(limit_addr)));
        if (issue_q == LAST_IDX) begin
          issue_d = '0;
          state_d = DRAIN;
        end else begin
          issue_d = issue_q + 1'b1;
        end
      end
      DRAIN: begin
        // Publish from work_d so the final capture lands in the same edge.
        if (!pipe_busy) begin
          samples_d = work_d;
          fc_d      = fc_q + 1'b1;
          state_d   = PUBLISH;
        end
      end
      PUBLISH: begin
        issue_d = '0;
        state_d = continuous ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      issue_q   <= '0;
      work_q    <= '0;
      samples_q <= '0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      issue_q   <= issue_d;
      work_q    <= work_d;
      samples_q <= samples_d;
      fc_q      <= fc_d;
    end
  end

  assign ram_rden    = (state_q == FETCH);
  assign ram_addr    = rd_ptr_q;
  assign samples     = samples_q;
  assign frame_valid = (state_q == PUBLISH);
  assign busy        = (state_q != IDLE);
  assign frame_count = fc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sample_frame_fetch.sv
// Directed bench for sample_frame_fetch with a 2-cycle-latency RAM model.
module tb_sample_frame_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         continuous;
  logic [14:0]  base_addr;
  logic [14:0]  limit_addr;
  logic [14:0]  ram_addr;
  logic         ram_rden;
  logic [15:0]  ram_q;
  logic [255:0] samples;
  logic         frame_valid;
  logic         busy;
  logic [15:0]  frame_count;
  logic [1:0]   dbg_state;

  logic [15:0] mem [0:32767];
  logic [15:0] q1, q2;

  int checks = 0;
  int errors = 0;

  int          fv_log[$];
  logic [14:0] addr_log[$];
  logic [14:0] exp_q[$];
  logic         busy_at [0:199];
  logic         rden_at [0:199];
  logic         fv_at   [0:199];
  logic [14:0]  addr_at [0:199];
  logic [15:0]  fc_at   [0:199];
  logic [255:0] samp_at [0:199];
  logic         early_change;

  sample_frame_fetch #(
    .ADDR_W(15), .DATA_W(16), .NUM_SAMPLES(16), .RD_LATENCY(2)
  ) dut (
    .Clk(clk), .Reset(rst), .start(start), .continuous(continuous),
    .base_addr(base_addr), .limit_addr(limit_addr),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_q(ram_q),
    .samples(samples), .frame_valid(frame_valid), .busy(busy),
    .frame_count(frame_count), .dbg_state(dbg_state)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rden) q1 <= mem[ram_addr];
    q2 <= q1;
  end
  assign ram_q = q2;

  function automatic logic [15:0] exp_s(input logic [15:0] r);
`ifdef SAMPLE_ABS_EN
    if (r == 16'h8000) return 16'h7FFF;
    if (r[15]) return (~r) + 16'd1;
    return r;
`else
    return r;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle 0 is the cycle with start high in IDLE; each cycle sampled at negedge.
  task automatic run_seq(input logic [14:0] b, input logic [14:0] l, input logic cont,
                         input int ncyc, input int drop_cyc, input int start2_cyc,
                         input int rst_cyc);
    logic [255:0] samples_before;
    fv_log.delete();
    addr_log.delete();
    early_change = 1'b0;
    @(posedge clk); #1;
    base_addr = b; limit_addr = l; continuous = cont; start = 1'b1;
    samples_before = samples;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (frame_valid) fv_log.push_back(c);
      if (ram_rden) addr_log.push_back(ram_addr);
      busy_at[c] = busy; rden_at[c] = ram_rden; fv_at[c] = frame_valid;
      addr_at[c] = ram_addr; fc_at[c] = frame_count; samp_at[c] = samples;
      if (c >= 1 && c <= 18 && samples !== samples_before) early_change = 1'b1;
      @(posedge clk); #1;
      start = (c + 1 == start2_cyc);
      rst   = (c + 1 == rst_cyc);
      if (c + 1 == drop_cyc) continuous = 1'b0;
    end
    start = 1'b0; rst = 1'b0; continuous = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%0b exp=0", frame_valid); end
    checks++; if (ram_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got=%0b exp=0", ram_rden); end
    checks++; if (ram_addr !== 15'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
    checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_fc got=%h exp=0", frame_count); end
    checks++; if (samples !== 256'h0) begin errors++; $display("FAIL reset_samples got=%h exp=0", samples); end
  endtask

  task automatic test_single();
    do_reset();
    run_seq(15'h0, 15'h7FFF, 1'b0, 24, -1, -1, -1);
    checks++;
    if (fv_log.size() != 1 || fv_log[0] != 19) begin
      errors++; $display("FAIL single_fv_cycle got_n=%0d first=%0d exp=19", fv_log.size(),
                         fv_log.size() > 0 ? fv_log[0] : -1);
    end
    checks++; if (busy_at[19] !== 1'b1) begin errors++; $display("FAIL single_busy19 got=%0b exp=1", busy_at[19]); end
    checks++; if (busy_at[20] !== 1'b0) begin errors++; $display("FAIL single_busy20 got=%0b exp=0", busy_at[20]); end
    checks++; if (fc_at[23] !== 16'd1) begin errors++; $display("FAIL single_fc got=%0d exp=1", fc_at[23]); end
    checks++; if (early_change) begin errors++; $display("FAIL single_early_samples got=changed exp=stable"); end
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(15'(i));
    checks++; if (addr_log != exp_q) begin errors++; $display("FAIL single_addr_seq got_n=%0d exp_n=16", addr_log.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (samp_at[20][i*16 +: 16] !== 16'h100 + 16'(i)) begin
        errors++; $display("FAIL single_sample%0d got=%h exp=%h", i, samp_at[20][i*16 +: 16], 16'h100 + 16'(i));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_seq(15'h10, 15'h17, 1'b0, 24, -1, -1, -1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(15'h10 + 15'(i % 8));
    checks++; if (addr_log != exp_q) begin errors++; $display("FAIL wrap_addr_seq got_n=%0d exp_n=16", addr_log.size()); end
    checks++;
    if (samp_at[21][8*16 +: 16] !== exp_s(mem[15'h10])) begin
      errors++; $display("FAIL wrap_sample8 got=%h exp=%h", samp_at[21][8*16 +: 16], exp_s(mem[15'h10]));
    end
    checks++;
    if (samp_at[21][15*16 +: 16] !== 16'h117) begin
      errors++; $display("FAIL wrap_sample15 got=%h exp=0117", samp_at[21][15*16 +: 16]);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    run_seq(15'h0, 15'h7FFF, 1'b1, 85, 60, -1, -1);
    checks++;
    if (fv_log.size() != 4 || fv_log[0] != 19 || fv_log[1] != 38 || fv_log[2] != 57 || fv_log[3] != 76) begin
      errors++; $display("FAIL cont_fv_cycles got_n=%0d exp=19,38,57,76", fv_log.size());
    end
    checks++; if (fc_at[58] !== 16'd3) begin errors++; $display("FAIL cont_fc3 got=%0d exp=3", fc_at[58]); end
    checks++;
    if (addr_log.size() != 64 || addr_log[32] !== 15'd32) begin
      errors++; $display("FAIL cont_frame3_addr got_n=%0d exp_n=64 exp_addr=32", addr_log.size());
    end
    checks++; if (busy_at[77] !== 1'b0) begin errors++; $display("FAIL cont_idle_after got=%0b exp=0", busy_at[77]); end
    checks++; if (fc_at[84] !== 16'd4) begin errors++; $display("FAIL cont_fc4 got=%0d exp=4", fc_at[84]); end
    checks++;
    if (samp_at[84][0 +: 16] !== 16'h130) begin
      errors++; $display("FAIL cont_frame4_s0 got=%h exp=0130", samp_at[84][0 +: 16]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_seq(15'h0, 15'h7FFF, 1'b0, 22, -1, -1, -1);
    checks++; if (samp_at[21][0 +: 16] !== 16'h100) begin errors++; $display("FAIL rmid_pre_sample got=%h exp=0100", samp_at[21][0 +: 16]); end
    run_seq(15'h20, 15'h7FFF, 1'b0, 30, -1, -1, 7);
    checks++; if (busy_at[8] !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0b exp=0", busy_at[8]); end
    checks++; if (rden_at[8] !== 1'b0) begin errors++; $display("FAIL rmid_rden got=%0b exp=0", rden_at[8]); end
    checks++; if (addr_at[8] !== 15'h0) begin errors++; $display("FAIL rmid_addr got=%h exp=0", addr_at[8]); end
    checks++; if (fc_at[8] !== 16'h0) begin errors++; $display("FAIL rmid_fc got=%0d exp=0", fc_at[8]); end
    checks++; if (samp_at[8] !== 256'h0) begin errors++; $display("FAIL rmid_samples got=%h exp=0", samp_at[8]); end
    checks++; if (fv_log.size() != 0) begin errors++; $display("FAIL rmid_no_fv got=%0d exp=0", fv_log.size()); end
    checks++; if (busy_at[29] !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%0b exp=0", busy_at[29]); end
  endtask

  task automatic test_ignored_start();
    do_reset();
    run_seq(15'h0, 15'h7FFF, 1'b0, 22, -1, -1, -1);
    run_seq(15'h40, 15'h7FFF, 1'b0, 30, -1, 17, -1);
    checks++;
    if (fv_log.size() != 1 || fv_log[0] != 19) begin
      errors++; $display("FAIL ign_fv got_n=%0d exp=1 at 19", fv_log.size());
    end
    checks++; if (early_change) begin errors++; $display("FAIL ign_atomic got=changed exp=stable"); end
    checks++; if (addr_log.size() != 16) begin errors++; $display("FAIL ign_reads got=%0d exp=16", addr_log.size()); end
    checks++; if (busy_at[25] !== 1'b0) begin errors++; $display("FAIL ign_idle got=%0b exp=0", busy_at[25]); end
    checks++; if (fc_at[29] !== 16'd2) begin errors++; $display("FAIL ign_fc got=%0d exp=2", fc_at[29]); end
    checks++; if (samp_at[18][0 +: 16] !== 16'h100) begin errors++; $display("FAIL ign_old_s0 got=%h exp=0100", samp_at[18][0 +: 16]); end
    checks++; if (samp_at[20][0 +: 16] !== 16'h140) begin errors++; $display("FAIL ign_new_s0 got=%h exp=0140", samp_at[20][0 +: 16]); end
  endtask

  task automatic test_abs_and_single_addr();
    logic [15:0] e0, e1, e2;
    mem[15'h200] = 16'hFFFF; mem[15'h201] = 16'h8000; mem[15'h202] = 16'h0005;
`ifdef SAMPLE_ABS_EN
    e0 = 16'h0001; e1 = 16'h7FFF; e2 = 16'h0005;
`else
    e0 = 16'hFFFF; e1 = 16'h8000; e2 = 16'h0005;
`endif
    do_reset();
    run_seq(15'h200, 15'h202, 1'b0, 22, -1, -1, -1);
    checks++; if (samp_at[21][0 +: 16] !== e0) begin errors++; $display("FAIL abs_s0 got=%h exp=%h", samp_at[21][0 +: 16], e0); end
    checks++; if (samp_at[21][16 +: 16] !== e1) begin errors++; $display("FAIL abs_s1 got=%h exp=%h", samp_at[21][16 +: 16], e1); end
    checks++; if (samp_at[21][32 +: 16] !== e2) begin errors++; $display("FAIL abs_s2 got=%h exp=%h", samp_at[21][32 +: 16], e2); end
    checks++; if (samp_at[21][48 +: 16] !== e0) begin errors++; $display("FAIL abs_s3 got=%h exp=%h", samp_at[21][48 +: 16], e0); end
    run_seq(15'h300, 15'h300, 1'b0, 22, -1, -1, -1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(15'h300);
    checks++; if (addr_log != exp_q) begin errors++; $display("FAIL same_base_limit_addr got_n=%0d exp_n=16", addr_log.size()); end
    checks++; if (samp_at[21][15*16 +: 16] !== 16'h400) begin errors++; $display("FAIL same_base_limit_s15 got=%h exp=0400", samp_at[21][15*16 +: 16]); end
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 16'(a + 16'h100);
    q1 = '0; q2 = '0;
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    base_addr = '0; limit_addr = '0;
    test_reset();
    test_single();
    test_wrap();
    test_continuous();
    test_reset_mid();
    test_ignored_start();
    test_abs_and_single_addr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_frame_fetch.md
Name: sample_frame_fetch

Overview:
Parametrised RAM-to-register sample fetcher for the audio visualizer datapath. It reads frames of NUM_SAMPLES consecutive words from a synchronous block RAM with fixed read latency, using pipelined back-to-back reads. Completed frames are published atomically to a double-buffered output bank, so bar_graph and color_mapper never see a half-updated frame. It supports single-shot and continuous modes, with address wrap inside a circular sample region.

Parameters:
ADDR_W, 15, RAM address width
DATA_W, 16, sample width in bits
NUM_SAMPLES, 16, samples per frame (>=2)
RD_LATENCY, 2, RAM cycles from rden/address to valid q (>=1)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
start  in  1  begin fetch; sampled only in IDLE
continuous  in  1  1 = refetch next frame automatically after publish
base_addr  in  ADDR_W  first address of circular region; loaded on start
limit_addr  in  ADDR_W  last address of region, inclusive (>= base_addr)
ram_addr  out  ADDR_W  RAM read address
ram_rden  out  1  RAM read enable
ram_q  in  DATA_W  RAM read data
samples  out  NUM_SAMPLES*DATA_W  published frame; sample i at [i*DATA_W +: DATA_W]
frame_valid  out  1  one-cycle pulse when samples updates
busy  out  1  high in any state except IDLE
frame_count  out  16  published-frame counter, wraps at 0xFFFF->0

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is Clk, reset port is Reset.
- Reset values: samples=0, frame_valid=0, busy=0, ram_rden=0, ram_addr=0, frame_count=0, state=IDLE, working buffer=0, in-flight pipeline cleared.
- States:
  - IDLE: if start=1, load rd_ptr<=base_addr and issue=0, then go to FETCH.
  - FETCH: ram_rden=1 and ram_addr=rd_ptr every cycle. rd_ptr advances by 1 per cycle; at limit_addr it wraps to base_addr. After NUM_SAMPLES issues, go to DRAIN.
  - DRAIN: ram_rden=0. Wait until all in-flight reads return, then go to PUBLISH.
  - PUBLISH: copy working buffer to samples, frame_valid=1 for this cycle only, frame_count++. Next state is FETCH if continuous=1, otherwise IDLE.
- In continuous mode, rd_ptr is NOT reloaded between frames. The stream continues through the circular region.
- Capture pipeline: an RD_LATENCY-deep shift register carries {valid, index}. When the tail is valid, ram_q is written to working[index].
- Latency: take start high in IDLE as cycle 0.
  - Reads are issued in cycles 1..N.
  - Last capture happens at the end of cycle N+RD_LATENCY.
  - frame_valid is high in cycle N+RD_LATENCY+1. For the defaults, that is cycle 19.
- Continuous frame period: N+RD_LATENCY+1 cycles.
- samples changes only on the PUBLISH edge and holds between publishes.
- start outside IDLE is ignored. Deasserting continuous mid-frame finishes the current frame, then returns to IDLE.
- base_addr and limit_addr are read at every wrap. Changing them mid-frame takes effect at the next wrap.
- If limit_addr==base_addr, every read targets base_addr.
- Reset in any state aborts the operation: in-flight data is discarded and the block returns to IDLE with reset values.

Optional Feature:
SAMPLE_ABS_EN
- Defined: ram_q is treated as two's complement, and working[index] stores its magnitude. The most negative value saturates to 2^(DATA_W-1)-1. Conversion is combinational on the capture path and adds no latency.
- Undefined: ram_q is stored unmodified.

Decomposition:
- Package sample_fetch_pkg:
  - state enum fetch_state_t {IDLE, FETCH, DRAIN, PUBLISH}
  - FRAME_CNT_W=16 constant
  - wrap-increment function next_addr(ptr, base, limit)
- Sub-module rd_latency_pipe holds the RD_LATENCY-stage {valid, index} shift register, parametrised on depth and index width.

Test Plan:
- Single-shot frame:
  - Setup: RAM[i]=i+0x100, base=0, limit=0x7FFF; start pulse at cycle 0 with continuous=0.
  - Expect: frame_valid only in cycle 19; samples[i]=0x100+i; busy drops in cycle 20; frame_count=1.
- Wrap-around:
  - Setup: base=0x10, limit=0x17 (8 words), N=16.
  - Expect: ram_addr sequence 0x10..0x17,0x10..0x17; sample 8 equals RAM[0x10].
- Continuous mode:
  - Stimulus: continuous=1 for 3 frames.
  - Expect: frame_valid pulses at cycles 19, 38, 57; third frame starts at address base+32; frame_count=3. Then drop continuous mid-frame 4; expect a 4th pulse followed by IDLE.
- Reset mid-fetch:
  - Stimulus: Reset high in cycle 7 of FETCH.
  - Expect: next cycle all outputs at reset values; no frame_valid; previously published samples cleared to 0.
- Ignored start / atomicity:
  - Stimulus: pulse start during DRAIN.
  - Expect: no effect. samples stays unchanged across cycles 1..18 and changes only on the publish edge.
- SAMPLE_ABS_EN defined:
  - Setup: RAM = {0xFFFF, 0x8000, 0x0005}.
  - Expect: samples 0x0001, 0x7FFF, 0x0005. With the macro undefined, expect the raw values.
